// File: rtl/sum_accumulator.sv
// Sum accumulator: adds BATCH 9-bit operands {in_carry,in_sum} into a 16-bit total and
// presents it through a valid/ready handshake. Define SUM_ACCUMULATOR_SAT_EN to clamp at 0xFFFF.
module sum_accumulator #(
  parameter int BATCH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_sum,
  input  logic        in_carry,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        clear,
  output logic [15:0] out_data,
  output logic        out_ovf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [7:0] BATCH_CNT = 8'(BATCH);

  state_t      state, state_nxt;
  logic [15:0] acc, acc_nxt;
  logic        ovf, ovf_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [16:0] sum;
  logic [7:0]  cnt_inc;

  // Handshake flags are decoded from state alone, so they carry no input-to-output path.
  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign out_data  = acc;
  assign out_ovf   = ovf;
  assign count     = cnt;

  assign sum     = {1'b0, acc} + {8'b0, in_carry, in_sum};
  assign cnt_inc = cnt + 8'd1;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      ovf   <= ovf_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    ovf_nxt   = ovf;
    cnt_nxt   = cnt;
    if (clear || (out_valid && out_ready)) begin
      // Abort and result delivery both drop the batch; clear wins over any operand.
      state_nxt = IDLE;
      acc_nxt   = '0;
      ovf_nxt   = 1'b0;
      cnt_nxt   = '0;
    end else if (in_valid && in_ready) begin
`ifdef SUM_ACCUMULATOR_SAT_EN
      acc_nxt = sum[16] ? 16'hFFFF : sum[15:0];
`else
      acc_nxt = sum[15:0];
`endif
      ovf_nxt   = ovf | sum[16];
      cnt_nxt   = cnt_inc;
      state_nxt = (cnt_inc == BATCH_CNT) ? HOLD : ACCUM;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator: directed scenarios plus randomized batches
// compared against a plain-arithmetic model of the batch total.
module tb_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_sum;
  logic        in_carry, in_valid, clear, out_ready;
  logic        in_ready, out_ovf, out_valid;
  logic [15:0] out_data;
  logic [7:0]  count;

  logic        b_valid, b_in_ready, b_out_ovf, b_out_valid;
  logic [15:0] b_out_data;
  logic [7:0]  b_count;

  logic        c_valid, c_in_ready, c_out_ovf, c_out_valid;
  logic [15:0] c_out_data;
  logic [7:0]  c_count;

  int total = 0;
  int passed = 0;
  int failed = 0;
  int exp_sum = 0;
  int exp_n = 0;

  always #5 clk = ~clk;

  sum_accumulator #(.BATCH(4)) dut (
    .clk(clk), .rst(rst), .in_sum(in_sum), .in_carry(in_carry), .in_valid(in_valid),
    .in_ready(in_ready), .clear(clear), .out_data(out_data), .out_ovf(out_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .count(count)
  );

  sum_accumulator #(.BATCH(255)) dut255 (
    .clk(clk), .rst(rst), .in_sum(in_sum), .in_carry(in_carry), .in_valid(b_valid),
    .in_ready(b_in_ready), .clear(clear), .out_data(b_out_data), .out_ovf(b_out_ovf),
    .out_valid(b_out_valid), .out_ready(out_ready), .count(b_count)
  );

  sum_accumulator #(.BATCH(1)) dut1 (
    .clk(clk), .rst(rst), .in_sum(in_sum), .in_carry(in_carry), .in_valid(c_valid),
    .in_ready(c_in_ready), .clear(clear), .out_data(c_out_data), .out_ovf(c_out_ovf),
    .out_valid(c_out_valid), .out_ready(out_ready), .count(c_count)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic void model_clear();
    exp_sum = 0;
    exp_n   = 0;
  endfunction

  function automatic void model_add(input logic [8:0] op);
    exp_sum += int'(op);
    exp_n++;
  endfunction

  function automatic logic exp_ovf();
    return exp_sum > 65535;
  endfunction

  function automatic logic [15:0] exp_data();
`ifdef SUM_ACCUMULATOR_SAT_EN
    if (exp_sum > 65535) return 16'hFFFF;
`endif
    return 16'(exp_sum % 65536);
  endfunction

  task automatic set_op(input logic [8:0] op);
    in_sum   = op[7:0];
    in_carry = op[8];
  endtask

  // Accept one operand on the next edge (caller guarantees in_ready=1).
  task automatic feed(input logic [8:0] op);
    set_op(op);
    in_valid = 1'b1;
    @(negedge clk);
    model_add(op);
    in_valid = 1'b0;
  endtask

  task automatic check_hold(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"},  32'(out_data),  32'(exp_data()));
    chk({tag, "_ovf"},   32'(out_ovf),   32'(exp_ovf()));
    chk({tag, "_count"}, 32'(count),     32'd4);
    chk({tag, "_rdy"},   32'(in_ready),  32'd0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"},  32'(out_data),  32'd0);
    chk({tag, "_ovf"},   32'(out_ovf),   32'd0);
    chk({tag, "_count"}, 32'(count),     32'd0);
    chk({tag, "_rdy"},   32'(in_ready),  32'd1);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    model_clear();
    check_idle(tag);
  endtask

  initial begin
    logic [8:0] ops [4];
    logic [15:0] held;
    logic [8:0] op;
    rst = 1'b1; in_sum = '0; in_carry = 1'b0; in_valid = 1'b0; clear = 1'b0;
    out_ready = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    #3;
    check_idle("reset");
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back batch with out_ready high: result visible for exactly one cycle.
    ops = '{9'h010, 9'h020, 9'h030, 9'h040};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    foreach (ops[i]) begin
      set_op(ops[i]);
      @(negedge clk);
      model_add(ops[i]);
    end
    in_valid = 1'b0;
    chk("b2b_expect_a0", 32'(exp_data()), 32'h00A0);
    check_hold("b2b");
    @(negedge clk);
    model_clear();
    check_idle("b2b_done");
    out_ready = 1'b0;

    // Full 9-bit operands, then a 5-cycle stall with in_valid held high.
    repeat (4) feed(9'h1FF);
    check_hold("max_op");
    held = out_data;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rdy",  32'(in_ready), 32'd0);
      chk("stall_data", 32'(out_data), 32'(held));
      chk("stall_cnt",  32'(count),    32'd4);
    end
    handshake("stall_release");
    in_valid = 1'b0;

    // Clear together with the third operand drops it.
    feed(9'h010);
    feed(9'h020);
    set_op(9'h030);
    in_valid = 1'b1;
    clear    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b0;
    model_clear();
    check_idle("clr_mid");
    for (int i = 1; i <= 4; i++) feed(9'(i));
    check_hold("after_clr");
    chk("after_clr_a", 32'(out_data), 32'h000A);

    // Clear while a result is pending discards it.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    check_idle("clr_hold");

    // Asynchronous reset in HOLD, between clock edges.
    repeat (4) feed(9'h0AA);
    check_hold("pre_rst");
    #2 rst = 1'b1;
    #1;
    model_clear();
    check_idle("async_rst");
    #1 rst = 1'b0;
    @(negedge clk);
    repeat (4) feed(9'h001);
    check_hold("post_rst");
    chk("post_rst_4", 32'(out_data), 32'h0004);
    handshake("post_rst_hs");

    // Randomized batches with gaps on in_valid and random stall lengths.
    for (int b = 0; b < 8; b++) begin
      while (exp_n < 4) begin
        chk("rnd_cnt", 32'(count), 32'(exp_n));
        op = 9'($urandom_range(0, 511));
        set_op(op);
        in_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (in_valid) model_add(op);
      end
      in_valid = 1'b0;
      check_hold("rnd");
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("rnd_stall", 32'(out_data), 32'(exp_data()));
      end
      in_valid = 1'b0;
      handshake("rnd_hs");
    end

    // BATCH=1 goes straight from IDLE to HOLD.
    set_op(9'h123);
    c_valid = 1'b1;
    @(negedge clk);
    c_valid = 1'b0;
    chk("b1_valid", 32'(c_out_valid), 32'd1);
    chk("b1_data",  32'(c_out_data),  32'h0123);
    chk("b1_count", 32'(c_count),     32'd1);
    chk("b1_rdy",   32'(c_in_ready),  32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("b1_done", 32'(c_out_valid), 32'd0);

    // BATCH=255 of 0x1FF: overflow first appears on the 129th operand.
    set_op(9'h1FF);
    b_valid = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      @(negedge clk);
      model_add(9'h1FF);
      if (i == 128) chk("b255_no_ovf", 32'(b_out_ovf), 32'(exp_ovf()));
      if (i == 129) chk("b255_ovf",    32'(b_out_ovf), 32'(exp_ovf()));
    end
    b_valid = 1'b0;
`ifdef SUM_ACCUMULATOR_SAT_EN
    chk("b255_expect", 32'(exp_data()), 32'hFFFF);
`else
    chk("b255_expect", 32'(exp_data()), 32'hFD01);
`endif
    chk("b255_valid", 32'(b_out_valid), 32'd1);
    chk("b255_data",  32'(b_out_data),  32'(exp_data()));
    chk("b255_ovfh",  32'(b_out_ovf),   32'd1);
    chk("b255_count", 32'(b_count),     32'd255);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("b255_done_valid", 32'(b_out_valid), 32'd0);
    chk("b255_done_ovf",   32'(b_out_ovf),   32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 The block SHALL have one clock and asynchronous active-high reset, with ports as listed below.
REQ-002 Parameter BATCH, default 4, number of sums accumulated per result; legal range 1..255.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_sum  input  8  low 8 bits of the upstream adder sum.
REQ-006 in_carry  input  1  carry-out of the upstream adder, forming the 9-bit operand {in_carry,in_sum}.
REQ-007 in_valid  input  1  upstream operand valid.
REQ-008 in_ready  output  1  block accepts the operand this cycle.
REQ-009 clear  input  1  synchronous abort of the current batch.
REQ-010 out_data  output  16  batch total.
REQ-011 out_ovf  output  1  batch total exceeded 0xFFFF.
REQ-012 out_valid  output  1  out_data/out_ovf valid.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 count  output  8  operands accepted in the current batch.

Function
REQ-015 The input handshake SHALL complete on an edge where in_valid=1 and in_ready=1; the output handshake SHALL complete on an edge where out_valid=1 and out_ready=1.
REQ-016 The FSM SHALL have the states IDLE (count=0), ACCUM (0<count<BATCH) and HOLD (result presented).
REQ-017 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD; out_valid SHALL be 1 only in HOLD.
REQ-018 Each input handshake SHALL add the zero-extended 9-bit operand to a 16-bit accumulator and increment count.
REQ-019 On an input handshake that sets count to BATCH, the state SHALL be HOLD after that edge, with out_data equal to the total including that operand (latency of one edge, no extra cycle).
REQ-020 When BATCH=1, the block SHALL go directly from IDLE to HOLD.
REQ-021 Overflow: if an addition carries out of bit 15, out_ovf SHALL become 1 and stay 1 (sticky) until the batch ends; in default mode the accumulator SHALL wrap modulo 2^16.
REQ-022 In HOLD, out_data, out_ovf and count SHALL stay stable while out_ready=0, for any number of cycles.
REQ-023 On the output handshake, the accumulator, out_ovf and count SHALL clear, and the state SHALL be IDLE after the edge; no operand is accepted on that edge.
REQ-024 clear=1 SHALL force IDLE with accumulator, count and out_ovf at 0 in any state, including HOLD (the result is discarded).
REQ-025 clear SHALL take priority over a simultaneous input or output handshake; that operand is not accumulated.
REQ-026 out_data SHALL be driven from registers with no combinational path from inputs; in_ready SHALL depend only on state.

Reset
REQ-027 While rst=1, the state SHALL be IDLE with out_data=0x0000, out_ovf=0, out_valid=0, count=0 and in_ready=1, independent of clk.
REQ-028 Reset asserted during ACCUM or HOLD SHALL discard the partial or pending result; after release, the first accepted operand SHALL start a new batch.

Configuration
REQ-029 Macro SUM_ACCUMULATOR_SAT_EN: when defined, an overflowing addition SHALL clamp the accumulator at 0xFFFF, it SHALL stay at 0xFFFF for the rest of the batch, and out_ovf SHALL still be set.
REQ-030 When SUM_ACCUMULATOR_SAT_EN is undefined, the wrap behaviour of REQ-021 SHALL apply and no saturation logic SHALL be present.

Verification
REQ-031 BATCH=4, operands 0x010,0x020,0x030,0x040 back-to-back with out_ready=1 -> out_valid for exactly one cycle, out_data=0x00A0, out_ovf=0, count=4.
REQ-032 BATCH=4, operand {1,0xFF}=0x1FF four times -> out_data=0x07FC, out_ovf=0.
REQ-033 BATCH=4, out_ready=0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0 throughout, out_data stable; after out_ready=1 -> IDLE on the next edge.
REQ-034 BATCH=4, clear pulsed together with the 3rd operand -> count=0, the 3rd operand is dropped; next batch 1,2,3,4 -> out_data=0x000A.
REQ-035 BATCH=255, 0x1FF x255 -> default out_data=0xFD01 with out_ovf=1; with SUM_ACCUMULATOR_SAT_EN out_data=0xFFFF with out_ovf=1.
REQ-036 rst pulsed mid-cycle while in HOLD -> outputs immediately at reset values; next batch of 4 x 0x001 -> out_data=0x0004.
